// File: rtl/fp32_uart_pkg.sv
// fp32_uart_pkg: FSM state encoding and shared constants for the fp32 UART TX scheduler.
package fp32_uart_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_e;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [7:0] HDR_TAG = 8'hA0;
    localparam int BAUD_DIV = 434;
endpackage

// File: rtl/fp32_uart_tx_sched_if.sv
// fp32_uart_tx_sched_if: requester and serializer signals of the fp32 UART TX scheduler.
interface fp32_uart_tx_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]         req_valid_i;
    logic [32*N_REQ-1:0]      req_data_i;
    logic [N_REQ-1:0]         req_ready_o;
    logic [7:0]               tx_byte_o;
    logic                     tx_valid_o;
    logic                     tx_ready_i;
    logic [$clog2(N_REQ)-1:0] grant_id_o;
    logic                     busy_o;
    modport master (
        input  req_valid_i, req_data_i, tx_ready_i,
        output req_ready_o, tx_byte_o, tx_valid_o, grant_id_o, busy_o
    );
    modport slave (
        output req_valid_i, req_data_i, tx_ready_i,
        input  req_ready_o, tx_byte_o, tx_valid_o, grant_id_o, busy_o
    );
endinterface

// File: rtl/fp32_rr_arb.sv
// fp32_rr_arb: combinational round-robin pick of the first request at or after ptr.
module fp32_rr_arb #(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    id
);
    logic          hit;
    logic [IW-1:0] k;
    always_comb begin
        hit = 1'b0;
        id = '0;
        k = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = IW'((int'(ptr) + i) % N_REQ);
            if (en && !hit && req[k]) begin
                hit = 1'b1;
                id = k;
            end
        end
        gnt = hit ? N_REQ'(1) << id : '0;
    end
endmodule

// File: rtl/fp32_uart_tx_sched.sv
// fp32_uart_tx_sched: round-robin shares one byte UART TX among N_REQ fp32 word sources.
// Define FP32_UART_TX_HEADER_EN to prefix each frame with an 8'hA0|grant_id header byte.
module fp32_uart_tx_sched
    import fp32_uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = BAUD_DIV,
    parameter bit MSB_FIRST  = 1'b0
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    fp32_uart_tx_sched_if.master bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [1:0] IDLE = ST_IDLE, HDR = ST_HDR, SEND = ST_SEND, GAP = ST_GAP;
    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
    logic [1:0]       state, idx, sel;
    logic [GW-1:0]    gap_cnt;
    logic [31:0]      word;
    logic [IW-1:0]    ptr, gid, pick;
    logic [N_REQ-1:0] gnt;
    // Gating with rst_ni keeps the accept pulse low while reset is held.
    fp32_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req(bus.req_valid_i),
        .ptr(ptr),
        .en (state == IDLE && rst_ni),
        .gnt(gnt),
        .id (pick)
    );
    assign sel = MSB_FIRST ? LAST - idx : idx;
    assign bus.req_ready_o = gnt;
    assign bus.grant_id_o = gid;
    assign bus.busy_o = state != IDLE;
`ifdef FP32_UART_TX_HEADER_EN
    assign bus.tx_valid_o = state == SEND || state == HDR;
    assign bus.tx_byte_o = state == SEND ? word[8*sel +: 8] : state == HDR ? HDR_TAG | 8'(gid) : 8'h00;
`else
    assign bus.tx_valid_o = state == SEND;
    assign bus.tx_byte_o = state == SEND ? word[8*sel +: 8] : 8'h00;
`endif
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            ptr <= '0;
            gid <= '0;
            idx <= '0;
            gap_cnt <= '0;
            word <= '0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    word <= bus.req_data_i[32*pick +: 32];
                    gid <= pick;
                    ptr <= pick == IW'(N_REQ - 1) ? '0 : pick + 1'b1;
                    idx <= '0;
`ifdef FP32_UART_TX_HEADER_EN
                    state <= HDR;
`else
                    state <= SEND;
`endif
                end
`ifdef FP32_UART_TX_HEADER_EN
                HDR: if (bus.tx_ready_i) state <= SEND;
`endif
                SEND: if (bus.tx_ready_i) begin
                    idx <= idx + 1'b1;
                    if (idx == LAST) state <= GAP_CYCLES == 0 ? IDLE : GAP;
                end
                GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    gap_cnt <= '0;
                    state <= IDLE;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
